exu_lsu_ctrl: RTL

//  - EXU memory-access controller. Sits between IDU (upstream valid/ready) and WBU (downstream valid/ready).
//  - Drives an AXI4-Lite style master for loads (AR/R) and stores (AW/W/B); non-memory instructions pass straight through.
//  - Registers request address, data and strobe; captures read data and response status for WBU.

---
 rtl/exu_lsu_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/exu_lsu_ctrl.sv
// EXU load/store controller: IDU valid/ready in, WBU valid/ready out, AXI4-Lite style master for memory ops.
// Optional build macro LSU_TIMEOUT_EN adds a per-state watchdog that ends a stalled transaction with err_o.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for the next instruction from IDU
// RD_ADDR | AR channel valid, waiting for arready_i
// RD_DATA | R channel ready, waiting for rvalid_i
// WR_REQ  | AW and W valid, each dropped after its own handshake
// WR_RESP | B channel ready, waiting for bvalid_i
// DONE    | result presented to WBU until ready_post_i
module exu_lsu_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_pre_i,
    output logic                ready_pre_o,
    input  logic                is_load_i,
    input  logic                is_store_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic                we_o,
    output logic                valid_post_o,
    input  logic                ready_post_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                arvalid_o,
    output logic [ADDR_W-1:0]   araddr_o,
    input  logic                arready_i,
    input  logic                rvalid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp_i,
    output logic                rready_o,
    output logic                awvalid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    input  logic                awready_i,
    output logic                wvalid_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    input  logic                wready_i,
    input  logic                bvalid_i,
    input  logic [1:0]          bresp_i,
    output logic                bready_o
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                timeout;

`ifdef LSU_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0] tmo_inc;
    logic                 busy;

    always_comb begin
        busy    = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                  (state_q == S_WR_REQ)  || (state_q == S_WR_RESP);
        tmo_inc = tmo_q + 1'b1;
        timeout = busy && (tmo_inc == {TIMEOUT_W{1'b1}});
        tmo_d   = (!busy || (state_d != state_q)) ? '0 : tmo_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_q <= '0;
        else      tmo_q <= tmo_d;
    end
`else
    logic [TIMEOUT_W-1:0] tmo_unused;
    assign tmo_unused = '0;
    assign timeout    = 1'b0;
`endif

    assign ready_pre_o  = (state_q == S_IDLE);
    assign we_o         = valid_pre_i & ready_pre_o;
    assign valid_post_o = (state_q == S_DONE);
    assign arvalid_o    = (state_q == S_RD_ADDR);
    assign araddr_o     = addr_q;
    assign rready_o     = (state_q == S_RD_DATA);
    assign awvalid_o    = (state_q == S_WR_REQ) & ~aw_done_q;
    assign awaddr_o     = addr_q;
    assign wvalid_o     = (state_q == S_WR_REQ) & ~w_done_q;
    assign wdata_o      = wdata_q;
    assign wstrb_o      = wstrb_q;
    assign bready_o     = (state_q == S_WR_RESP);
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        case (state_q)
            S_IDLE: begin
                if (valid_pre_i) begin
                    addr_d    = addr_i;
                    wdata_d   = wdata_i;
                    wstrb_d   = wstrb_i;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (is_load_i)       state_d = S_RD_ADDR;
                    else if (is_store_i) state_d = S_WR_REQ;
                    else                 state_d = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (arready_i) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (rvalid_i) begin
                    rdata_d = rdata_i;
                    err_d   = |rresp_i;
                    state_d = S_DONE;
                end
            end
            S_WR_REQ: begin
                if (awvalid_o && awready_i) aw_done_d = 1'b1;
                if (wvalid_o && wready_i)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)  state_d   = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (bvalid_i) begin
                    err_d   = |bresp_i;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_post_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A handshake completing in the same cycle as the watchdog expiry takes precedence.
        if (timeout && (state_d == state_q)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
